// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_div_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    // Widest operand the magnitude helper handles
    localparam int MAG_MAXW = 64;

    // Iteration counter width for an NW-bit dividend
    function automatic int cnt_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

    // Magnitude of the w-bit two's-complement value held in v[w-1:0].
    // The result is one bit wider than w so the most-negative value
    // is represented exactly.
    function automatic logic [MAG_MAXW:0] magnitude(input logic [MAG_MAXW-1:0] v,
                                                    input int w);
        logic [MAG_MAXW:0] ext;
        logic              neg;
        neg = v[w-1];
        ext = {1'b0, v};
        for (int i = 0; i <= MAG_MAXW; i++) begin
            if (i >= w) begin
                ext[i] = neg;
            end
        end
        if (neg) begin
            ext = (~ext) + {{MAG_MAXW{1'b0}}, 1'b1};
        end
        return ext;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One radix-2 restoring iteration on magnitudes: shift the next dividend
// bit into the partial remainder, subtract the divisor when it fits.
module seq_div_step #(
    parameter int DW = 18
) (
    input  logic [DW:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [DW-1:0] dsr_mag,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW:0] shifted;
    logic [DW:0] dsr_ext;

    // The incoming remainder is always below |divisor| <= 2^(DW-1), so its
    // top bit is known zero and drops out of the shift.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[DW];

    // Compare/subtract on the shifted partial remainder
    always_comb begin
        shifted = {rem_in[DW-1:0], dvd_bit};
        dsr_ext = {1'b0, dsr_mag};
        q_bit   = (shifted >= dsr_ext);
        rem_out = q_bit ? (shifted - dsr_ext) : shifted;
    end

endmodule

// File: rtl/seq_div_signed.sv
// Multi-cycle signed divider: magnitudes are divided one quotient bit per
// cycle, signs and special cases are applied in a final fix-up cycle.
module seq_div_signed
    import seq_div_pkg::*;
#(
    parameter int NW = 48,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero,
    output logic          ovf
);

    localparam int CW = cnt_width(NW);
    localparam logic [NW-1:0] MOST_NEG = {1'b1, {(NW-1){1'b0}}};

    state_t state_reg, state_next;

    logic [NW-1:0] dividend_reg;
    logic [DW-1:0] divisor_reg;
    // Holds |dividend| at the start of CALC; dividend bits leave at the MSB
    // while quotient bits enter at the LSB, so it ends as |quotient|.
    logic [NW-1:0] shift_reg;
    logic [DW:0]   rem_reg;
    logic [DW-1:0] dsr_mag_reg;
    logic          q_neg_reg;
    logic          r_neg_reg;
    logic          dz_reg;
    logic          ovf_flag_reg;
    logic [CW-1:0] cnt_reg;

    logic [NW-1:0] quotient_reg;
    logic [DW-1:0] remainder_reg;
    logic          div_zero_reg;
    logic          ovf_reg;

    logic [MAG_MAXW:0] dvd_mag_full;
    logic [MAG_MAXW:0] dsr_mag_full;
    logic [DW:0]       step_rem;
    logic              step_q;

    // Operand magnitudes from the captured operands
    always_comb begin
        dvd_mag_full = magnitude(MAG_MAXW'(dividend_reg), NW);
        dsr_mag_full = magnitude(MAG_MAXW'(divisor_reg), DW);
    end

    // |dividend| never exceeds 2^(NW-1), so NW bits hold it; upper bits are zero
    logic unused_mag_bits;
    assign unused_mag_bits = ^{dvd_mag_full[MAG_MAXW:NW], dsr_mag_full[MAG_MAXW:DW]};

    seq_div_step #(
        .DW(DW)
    ) u_step (
        .rem_in (rem_reg),
        .dvd_bit(shift_reg[NW-1]),
        .dsr_mag(dsr_mag_reg),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = PREP;
            PREP:    state_next = CALC;
            CALC:    if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            shift_reg     <= '0;
            rem_reg       <= '0;
            dsr_mag_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            ovf_flag_reg  <= 1'b0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        div_zero_reg <= 1'b0;
                        ovf_reg      <= 1'b0;
                    end
                end
                PREP: begin
                    shift_reg    <= dvd_mag_full[NW-1:0];
                    dsr_mag_reg  <= dsr_mag_full[DW-1:0];
                    q_neg_reg    <= dividend_reg[NW-1] ^ divisor_reg[DW-1];
                    r_neg_reg    <= dividend_reg[NW-1];
                    dz_reg       <= (divisor_reg == '0);
                    ovf_flag_reg <= (dividend_reg == MOST_NEG) && (divisor_reg == '1);
                    rem_reg      <= '0;
                    cnt_reg      <= CW'(NW - 1);
                end
                CALC: begin
                    shift_reg <= {shift_reg[NW-2:0], step_q};
                    rem_reg   <= step_rem;
                    cnt_reg   <= cnt_reg - CW'(1);
                end
                FIX: begin
                    if (dz_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg[DW-1:0];
                        div_zero_reg  <= 1'b1;
                    end else if (ovf_flag_reg) begin
                        quotient_reg  <= MOST_NEG;
                        remainder_reg <= '0;
                        ovf_reg       <= 1'b1;
                    end else begin
                        quotient_reg  <= q_neg_reg ? -shift_reg : shift_reg;
                        remainder_reg <= r_neg_reg ? -rem_reg[DW-1:0] : rem_reg[DW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;
    assign ovf       = ovf_reg;

endmodule

// File: doc/seq_div_signed.md
Name: seq_div_signed

Overview:
- Multi-cycle signed integer divider; the inverse operation to the team's DSP multiply-accumulate path.
- Divides a PW-wide accumulator-format dividend by a BW-wide coefficient-format divisor, one quotient bit per cycle (radix-2 restoring, on magnitudes).
- Sits downstream of the MAC for normalisation and scaling.
- valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- NW, 48, dividend and quotient width (matches MAC output width)
- DW, 18, divisor and remainder width (matches MAC coefficient width)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- dividend  in  NW  signed dividend
- divisor  in  DW  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- quotient  out  NW  signed quotient, truncated toward zero
- remainder  out  DW  signed remainder, same sign as dividend (or zero)
- div_zero  out  1  divisor was zero
- ovf  out  1  dividend = most-negative and divisor = -1

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; quotient, remainder, div_zero, ovf = 0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge E0, register operands and go to PREP.
- PREP (1 cycle):
  - Form magnitudes |dividend| (NW+1 bits, so the most-negative value is handled) and |divisor|.
  - Record result signs; flag div_zero and ovf; clear the partial remainder; load iteration counter = NW-1.
  - Go to CALC.
- CALC (exactly NW cycles):
  - Each cycle: shift the next dividend MSB into the partial remainder (DW+1 bits).
  - If partial remainder >= |divisor|, subtract and shift in quotient bit 1; else shift in 0.
  - Counter decrements; at counter==0 go to FIX.
- FIX (1 cycle):
  - Negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Load output registers; go to DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid & out_ready: out_valid drops next edge; go to IDLE.
- Latency: out_valid rises after edge E0+NW+2, i.e. 50 cycles at default.
  - Latency is constant for all operands, including the special cases.
- in_ready=0 in every state except IDLE.
  - No new accept in the same cycle as the result handshake.
  - Minimum spacing between accepts is NW+4 cycles.
- div_zero: quotient = all ones, remainder = dividend[DW-1:0], div_zero=1, ovf=0.
- ovf (most-negative / -1): quotient = most-negative value (wraps), remainder = 0, ovf=1.
- Flags are valid only with out_valid and are cleared on entry to PREP of the next operation.
- in_valid during a busy state is ignored. The upstream must hold operands until accepted.
- Reset mid-operation aborts the operation; no partial result is ever presented.

Decomposition:
- Package seq_div_pkg holds:
  - state enum type (IDLE, PREP, CALC, FIX, DONE)
  - a localparam function for the counter width, $clog2(NW)
  - a magnitude function parameterised by width
- Optional sub-module seq_div_step: combinational compare/subtract/shift for one iteration. It keeps the CALC datapath separately testable.
- FSM and registers stay in the top.

Test Plan:
- Basic: dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0; out_valid exactly 50 cycles after accept.
- Signs:
  - -1000/7 -> q=-142, r=-6
  - 1000/-7 -> q=-142, r=6
  - -1000/-7 -> q=142, r=-6
- Special cases:
  - 1000/0 -> q=all ones, r=1000, div_zero=1
  - 0x800000000000 / -1 -> q=0x800000000000, r=0, ovf=1
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset abort: assert rst at cycle 20 of CALC -> out_valid=0 and in_ready=1 immediately. A following 50/5 op -> q=10, r=0.
- Random: 10k random signed operand pairs against a reference model with truncate-toward-zero semantics, with out_ready randomly throttled.
